serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//  Bit-serial N-bit adder controller: time-shares one 1-bit full-adder cell across WIDTH cycles.
//  Accepts a start request, adds A + B + Cin LSB-first, then presents Sum/Cout with a one-cycle done pulse.
//  It is the sequencing layer above the gate-level adder cells, for area-minimal arithmetic.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range >= 1
// PORTS
//  clk    input   1      rising-edge clock; the only clock
//  rst_n  input   1      asynchronous, active-low reset
//  start  input   1      request; sampled only in IDLE
//  A      input   WIDTH  operand A, captured on accepted start
//  B      input   WIDTH  operand B, captured on accepted start
//  Cin    input   1      carry-in, captured on accepted start
//  busy   output  1      1 while state != IDLE
//  done   output  1      one-cycle pulse: Sum/Cout just became valid
//  Sum    output  WIDTH  registered result
//  Cout   output  1      registered carry-out
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; busy=0, done=0, Sum=0, Cout=0.
//    Shift registers, carry register and bit counter are also cleared.
//  - FSM states: IDLE -> RUN -> DONE -> IDLE.
//  - IDLE, start=1 at edge T:
//    - latch A, B into operand shift regs and Cin into carry reg; count=0.
//    - go to RUN at T+1.
//  - IDLE, start=0: remain in IDLE.
//  - RUN, each cycle:
//    - {c,s} = opA[0] + opB[0] + carry, via the full-adder cell.
//    - shift opA and opB right by 1.
//    - shift s into the MSB of the internal sum shift reg; carry<=c; count++.
//  - RUN exit: after exactly WIDTH RUN cycles (count==WIDTH-1 on last), go to DONE.
//    - same edge: Sum<=sum shift reg incl. final bit, Cout<=final c.
//  - DONE (1 cycle): done=1, busy=1; next state IDLE unconditionally.
//  - Latency: start edge T -> done high during cycle T+WIDTH+1.
//    Earliest next accepted start is at edge T+WIDTH+2.
//  - start during RUN/DONE: ignored. It is not queued, and A/B/Cin changes have no effect.
//  - Sum/Cout: change only on the RUN->DONE edge. They hold the previous result during RUN and indefinitely in IDLE.
//  - Arithmetic: {Cout,Sum} == A + B + Cin, modulo 2^(WIDTH+1). No overflow flag; wrap is via Cout.
//  - Counter width: $clog2(WIDTH+1). WIDTH=1 gives a single RUN cycle.
//  - Reset mid-operation:
//    - immediate return to IDLE; all outputs 0.
//    - the partial result is discarded and no done pulse follows.
//  - done and busy are registered (glitch-free) outputs; there are no combinational paths from inputs to outputs.
// STRUCTURE
//  - Package serial_add_pkg: typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t.
//  - Sub-module fa_cell: 1-bit full adder built from two half_adder1 instances plus an OR for carry.
//    It is instantiated once and is the only arithmetic in the block.
//  - Top: FSM, operand/sum shift registers, carry register, bit counter, output registers.
// TESTING
//  1. Reset: hold rst_n=0 with start=1 -> busy=0, done=0, Sum=0, Cout=0 throughout.
//  2. WIDTH=8: A=8'h0F, B=8'h01, Cin=0, start at T -> done only at T+9; Sum=8'h10, Cout=0.
//  3. Carry chain wrap: A=8'hFF, B=8'h01, Cin=0 -> Sum=8'h00, Cout=1.
//     Then A=8'hFF, B=8'hFF, Cin=1 -> Sum=8'hFF, Cout=1.
//  4. Ignored start: start held high through RUN, with A changed to 8'hAA after acceptance.
//     -> result is that of the first operands.
//     -> Sum holds the old value until done; next start accepted at T+10.
//  5. Reset at RUN cycle 4 -> outputs 0 on the same cycle, no done pulse.
//     A subsequent start A=3, B=4 -> Sum=7.
//  6. WIDTH=4 exhaustive: all A, B, Cin combinations back-to-back.
//     -> every {Cout,Sum} == A+B+Cin, and exactly one done pulse per start.

Source files
------------

// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_pkg
// Purpose  : Shared types for the bit-serial adder controller.
//            sa_state_t : controller FSM encoding (IDLE -> RUN -> DONE).
// Revision : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

endpackage : serial_add_pkg
`default_nettype wire

// File: rtl/fa_cell.sv
`default_nettype none
// ============================================================================
// Module   : half_adder1 / fa_cell
// Purpose  : Gate-level 1-bit adder cells.
//            half_adder1 : i_a, i_b -> o_s (XOR), o_c (AND)
//            fa_cell     : i_a, i_b, i_cin -> o_sum, o_cout
//                          built from two half adders plus an OR for carry.
// Revision : 1.0 - initial release
// ============================================================================
module half_adder1 (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;
endmodule : half_adder1

module fa_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    logic w_s0;
    logic w_c0;
    logic w_c1;

    half_adder1 u_ha0 (
        .i_a (i_a),
        .i_b (i_b),
        .o_s (w_s0),
        .o_c (w_c0)
    );

    half_adder1 u_ha1 (
        .i_a (w_s0),
        .i_b (i_cin),
        .o_s (o_sum),
        .o_c (w_c1)
    );

    // The two half-adder carries can never both be 1, so OR suffices.
    assign o_cout = w_c0 | w_c1;
endmodule : fa_cell
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_ctrl
// Purpose  : Bit-serial WIDTH-bit adder. One fa_cell is time-shared over
//            WIDTH cycles, LSB first, computing {Cout,Sum} = A + B + Cin.
// Ports    : clk    - rising-edge clock
//            rst_n  - asynchronous active-low reset
//            start  - request, sampled only in IDLE
//            A, B   - operands, captured on accepted start
//            Cin    - carry-in, captured on accepted start
//            busy   - 1 while the controller is not IDLE (registered)
//            done   - one-cycle pulse, Sum/Cout just became valid (registered)
//            Sum    - registered result, held until the next completion
//            Cout   - registered carry-out
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int CW = $clog2(WIDTH + 1);

    sa_state_t        r_state;
    sa_state_t        w_next_state;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_sumsh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_shift;

    fa_cell u_fa (
        .i_a    (r_opa[0]),
        .i_b    (r_opb[0]),
        .i_cin  (r_carry),
        .o_sum  (w_s),
        .o_cout (w_c)
    );

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    // New sum bit enters at the MSB; after WIDTH shifts the LSB-first
    // stream lands in natural bit order. Written as shift/OR so that
    // WIDTH=1 needs no empty part-select.
    assign w_sum_shift = (r_sumsh >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start)  w_next_state = RUN;
            RUN:     if (w_last) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM state register; busy/done decoded from next state so they are
    // flops that track the state exactly.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            busy    <= (w_next_state != IDLE);
            done    <= (w_next_state == DONE);
        end
    end

    // ------------------------------------------------------------------
    // Datapath: operand/sum shift registers, carry, counter, outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opa   <= '0;
            r_opb   <= '0;
            r_sumsh <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            Sum     <= '0;
            Cout    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_opa   <= A;
                        r_opb   <= B;
                        r_carry <= Cin;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_opa   <= r_opa >> 1;
                    r_opb   <= r_opb >> 1;
                    r_sumsh <= w_sum_shift;
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + CW'(1);
                    // Result is published only on the RUN->DONE edge so
                    // Sum/Cout hold the previous answer while computing.
                    if (w_last) begin
                        Sum  <= w_sum_shift;
                        Cout <= w_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : serial_adder_ctrl
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder_ctrl
// Purpose  : Self-checking bench for serial_adder_ctrl (WIDTH=8 and WIDTH=4).
//            Stimulus pushes expected {Cout,Sum} and completion cycle into a
//            queue; per-instance monitors pop and compare on each done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

    typedef struct {
        logic [8:0] res;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    // WIDTH=8 instance
    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    // WIDTH=4 instance
    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       cin4 = 1'b0;
    logic       busy4, done4, cout4;
    logic [3:0] sum4;

    exp_t q8[$];
    exp_t q4[$];
    int   issued4 = 0;
    int   seen4 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .Cin(cin8),
        .busy(busy8), .done(done8), .Sum(sum8), .Cout(cout8)
    );

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4), .Cin(cin4),
        .busy(busy4), .done(done4), .Sum(sum4), .Cout(cout4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge. Waits for IDLE, then presents one request.
    // Accepting edge is cyc+1; done is seen at the negedge where cyc has
    // advanced by WIDTH more edges.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input logic [8:0] exp_res);
        int n = 0;
        while (busy8 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("dut8_idle_timeout", 1, 0);
        a8 = a; b8 = b; cin8 = ci; start8 = 1'b1;
        q8.push_back('{res: exp_res, cyc: cyc + 1 + 8});
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic ci);
        int n = 0;
        while (busy4 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("dut4_idle_timeout", 1, 0);
        a4 = a; b4 = b; cin4 = ci; start4 = 1'b1;
        q4.push_back('{res: 9'({1'b0, a} + {1'b0, b} + {4'b0, ci}), cyc: cyc + 1 + 4});
        issued4++;
        @(negedge clk);
        start4 = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Monitors
    // ------------------------------------------------------------------
    always @(negedge clk) begin : mon8
        exp_t e;
        if (rst_n && done8) begin
            if (q8.size() == 0) chk("dut8_spurious_done", 1, 0);
            else begin
                e = q8.pop_front();
                chk("dut8_sum", 64'(sum8), 64'(e.res[7:0]));
                chk("dut8_cout", 64'(cout8), 64'(e.res[8]));
                chk("dut8_done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin : mon4
        exp_t e;
        if (rst_n && done4) begin
            seen4++;
            if (q4.size() == 0) chk("dut4_spurious_done", 1, 0);
            else begin
                e = q4.pop_front();
                chk("dut4_result", 64'({cout4, sum4}), 64'(e.res[4:0]));
                chk("dut4_done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int c0;
        int n;

        // 1. Reset held with start asserted: everything stays at zero.
        start8 = 1'b1; start4 = 1'b1; a8 = 8'h55; b8 = 8'h66;
        repeat (4) begin
            @(negedge clk);
            chk("rst_busy8", 64'(busy8), 0);
            chk("rst_done8", 64'(done8), 0);
            chk("rst_sum8",  64'(sum8), 0);
            chk("rst_cout8", 64'(cout8), 0);
            chk("rst_busy4", 64'(busy4), 0);
        end
        start8 = 1'b0; start4 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // 2. Basic add with latency check in the monitor.
        issue8(8'h0F, 8'h01, 1'b0, 9'h010);
        // 3. Carry-chain wrap cases.
        issue8(8'hFF, 8'h01, 1'b0, 9'h100);
        issue8(8'hFF, 8'hFF, 1'b1, 9'h1FF);

        // 4. start held through RUN/DONE; A changes after acceptance.
        n = 0;
        while (busy8 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("dut8_idle_timeout", 1, 0);
        c0 = cyc;
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back('{res: 9'h046, cyc: c0 + 1 + 8});
        @(negedge clk);
        a8 = 8'hAA;
        // Previous result (1FF) must hold throughout RUN.
        for (int i = 0; i < 8; i++) begin
            chk("hold_during_run", 64'({cout8, sum8}), 64'h1FF);
            @(negedge clk);
        end
        // Now at c0+9 (done pulse); next negedge is IDLE with start still high,
        // so the request is accepted exactly at T+10 with the new A.
        @(negedge clk);
        chk("busy_before_reaccept", 64'(busy8), 0);
        q8.push_back('{res: 9'h0DE, cyc: cyc + 1 + 8});
        @(negedge clk);
        start8 = 1'b0;
        chk("busy_after_reaccept", 64'(busy8), 1);

        // 5. Reset in the middle of RUN: outputs clear, no done follows.
        n = 0;
        while (busy8 && n < 100) begin @(negedge clk); n++; end
        issue8(8'h21, 8'h43, 1'b0, 9'h064);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy8", 64'(busy8), 0);
        chk("midrst_done8", 64'(done8), 0);
        chk("midrst_sum8",  64'(sum8), 0);
        chk("midrst_cout8", 64'(cout8), 0);
        q8.delete();
        @(negedge clk);
        rst_n = 1'b1;
        // Any done8 in this window has an empty queue and is flagged.
        repeat (14) @(negedge clk);
        chk("midrst_no_pending", 64'(q8.size()), 0);
        issue8(8'h03, 8'h04, 1'b0, 9'h007);

        // 6. WIDTH=4 exhaustive, back-to-back.
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int ci = 0; ci < 2; ci++)
                    issue4(4'(a), 4'(b), 1'(ci));

        n = 0;
        while ((q4.size() != 0 || q8.size() != 0) && n < 200) begin
            @(negedge clk); n++;
        end
        repeat (3) @(negedge clk);
        chk("q8_drained", 64'(q8.size()), 0);
        chk("q4_drained", 64'(q4.size()), 0);
        chk("dut4_done_count", 64'(seen4), 64'(issued4));
        chk("dut4_issue_count", 64'(issued4), 512);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_adder_ctrl
`default_nettype wire
